// File: rtl/multi_gate_eval.sv
// multi_gate_eval: debounced switch vector evaluated by six gates,
// plus a key-stepped selector driving a single result bit.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  async active-low reset
//   sw     raw switch levels [WIDTH-1:0], active-high
//   key    raw mode-step button, active-low
//   led    gate results, active-low
//          {AND,NAND,OR,NOR,XOR,XNOR}
//   mode   selected function 0..5
//   y      selected function result, active-high
module multi_gate_eval #(
   parameter int WIDTH  = 4,
   parameter int DB_CNT = 240000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw,
   input  logic             key,
   output logic [5:0]       led,
   output logic [2:0]       mode,
   output logic             y
);

   localparam int CW = $clog2(DB_CNT);
   localparam logic [CW-1:0] CMAX = CW'(DB_CNT - 1);

   logic [WIDTH-1:0] r_sw_s1, r_sw_s2;
   logic [WIDTH-1:0] r_sw_prev, r_sw_db;
   logic             r_key_s1, r_key_s2;
   logic             r_key_prev, r_key_db;
   logic             r_key_arm;
   logic             r_smp_vld;
   logic [CW-1:0]    r_cnt;
   logic [2:0]       r_mode;
   logic [5:0]       r_z;
   logic             r_y;

   logic             w_tick;
   logic             w_cmp;
   logic [WIDTH-1:0] w_sw_eq;
   logic [WIDTH-1:0] w_sw_db_nxt;
   logic             w_key_upd;
   logic             w_key_db_nxt;
   logic             w_press;
   logic [5:0]       w_z_nxt;
   logic             w_y_nxt;

   assign w_tick = (r_cnt == CMAX);
   // first tick after reset only primes the
   // previous-sample registers
   assign w_cmp  = w_tick & r_smp_vld;

   assign w_sw_eq = ~(r_sw_s2 ^ r_sw_prev);
   assign w_sw_db_nxt = w_cmp ?
      ((r_sw_db & ~w_sw_eq) | (r_sw_s2 & w_sw_eq)) :
      r_sw_db;

   assign w_key_upd = w_cmp & (r_key_s2 == r_key_prev);
   assign w_key_db_nxt = w_key_upd ? r_key_s2 : r_key_db;
   // arm only once a release has been confirmed, so a press
   // held across reset release never steps the mode
   assign w_press = r_key_arm & r_key_db & ~w_key_db_nxt;

   always_comb begin
      w_z_nxt = {  &r_sw_db, ~&r_sw_db,
                   |r_sw_db, ~|r_sw_db,
                   ^r_sw_db, ~^r_sw_db };
      w_y_nxt = 1'b0;
      case (r_mode)
         3'd0:    w_y_nxt = w_z_nxt[5];
         3'd1:    w_y_nxt = w_z_nxt[4];
         3'd2:    w_y_nxt = w_z_nxt[3];
         3'd3:    w_y_nxt = w_z_nxt[2];
         3'd4:    w_y_nxt = w_z_nxt[1];
         3'd5:    w_y_nxt = w_z_nxt[0];
         default: w_y_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sw_s1    <= '0;
         r_sw_s2    <= '0;
         r_sw_prev  <= '0;
         r_sw_db    <= '0;
         r_key_s1   <= 1'b1;
         r_key_s2   <= 1'b1;
         r_key_prev <= 1'b1;
         r_key_db   <= 1'b1;
         r_key_arm  <= 1'b0;
         r_smp_vld  <= 1'b0;
         r_cnt      <= '0;
         r_mode     <= 3'd0;
         r_z        <= 6'd0;
         r_y        <= 1'b0;
      end else begin
         r_sw_s1  <= sw;
         r_sw_s2  <= r_sw_s1;
         r_key_s1 <= key;
         r_key_s2 <= r_key_s1;
         r_cnt    <= w_tick ? '0 : r_cnt + CW'(1);
         if (w_tick) begin
            r_sw_prev  <= r_sw_s2;
            r_key_prev <= r_key_s2;
            r_smp_vld  <= 1'b1;
         end
         r_sw_db  <= w_sw_db_nxt;
         r_key_db <= w_key_db_nxt;
         if (w_key_upd && r_key_s2)
            r_key_arm <= 1'b1;
         if (w_press)
            r_mode <= (r_mode == 3'd5) ?
                      3'd0 : r_mode + 3'd1;
         r_z <= w_z_nxt;
         r_y <= w_y_nxt;
      end
   end

   assign led  = ~r_z;
   assign mode = r_mode;
   assign y    = r_y;

endmodule

// File: tb/tb_multi_gate_eval.sv
// Testbench for multi_gate_eval (WIDTH=4, DB_CNT=4).
// Random settled stimulus checked against a count-based model.
module tb_multi_gate_eval;

   logic       clk;
   logic       rst_n;
   logic [3:0] sw;
   logic       key;
   logic [5:0] led;
   logic [2:0] mode;
   logic       y;

   int n_cmp;
   int n_bad;
   int m_mode;

   multi_gate_eval #(
      .WIDTH (4),
      .DB_CNT(4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .sw   (sw),
      .key  (key),
      .led  (led),
      .mode (mode),
      .y    (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // gate results from the number of set switches
   function automatic logic [5:0] ref_z(input logic [3:0] s);
      int c;
      logic a, o, x;
      c = $countones(s);
      a = (c == 4);
      o = (c > 0);
      x = (c % 2) == 1;
      return {a, !a, o, !o, x, !x};
   endfunction

   function automatic logic ref_y(input int m,
                                  input logic [3:0] s);
      logic [5:0] z;
      z = ref_z(s);
      return z[5 - m];
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input int hold);
      key = 1'b0;
      cyc(hold);
      key = 1'b1;
      cyc(16);
      m_mode = (m_mode + 1) % 6;
   endtask

   task automatic chk_all(input string nm,
                          input logic [3:0] s);
      n_cmp++;
      if (led !== ~ref_z(s)) begin
         n_bad++;
         $display("FAIL %s led: got %b want %b",
                  nm, led, ~ref_z(s));
      end
      n_cmp++;
      if (mode !== 3'(m_mode)) begin
         n_bad++;
         $display("FAIL %s mode: got %0d want %0d",
                  nm, mode, m_mode);
      end
      n_cmp++;
      if (y !== ref_y(m_mode, s)) begin
         n_bad++;
         $display("FAIL %s y: got %b want %b",
                  nm, y, ref_y(m_mode, s));
      end
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      sw     = 4'b0;
      key    = 1'b1;
      m_mode = 0;
      cyc(3);
      n_cmp++;
      if (led !== 6'b111111 || mode !== 3'd0 || y !== 1'b0) begin
         n_bad++;
         $display("FAIL reset: got led=%b mode=%0d y=%b want 111111/0/0",
                  led, mode, y);
      end
      #2 rst_n = 1'b1;
      cyc(1);
      n_cmp++;
      if (led !== 6'b101010 || y !== 1'b0) begin
         n_bad++;
         $display("FAIL first_edge: got led=%b y=%b want 101010/0",
                  led, y);
      end
   endtask

   task automatic test_patterns();
      logic [3:0] pats [4];
      pats[0] = 4'b1111;
      pats[1] = 4'b0111;
      pats[2] = 4'b0000;
      pats[3] = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         sw = pats[i];
         cyc(20);
         chk_all($sformatf("pat%0d", i), pats[i]);
      end
   endtask

   task automatic test_mode_cycle();
      sw = 4'b0111;
      cyc(20);
      for (int i = 0; i < 6; i++) begin
         press(12);
         chk_all($sformatf("step%0d", i), sw);
      end
   endtask

   task automatic test_glitch();
      int bad;
      sw = 4'b0000;
      cyc(20);
      sw = 4'b0001;
      cyc(2);
      sw = 4'b0000;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (led !== 6'b101010) bad++;
         cyc(1);
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL glitch: got %0d bad cycles want 0", bad);
      end
   endtask

   task automatic test_hold();
      int m0;
      m0 = m_mode;
      key = 1'b0;
      cyc(200);
      n_cmp++;
      if (mode !== 3'((m0 + 1) % 6)) begin
         n_bad++;
         $display("FAIL hold: got %0d want %0d",
                  mode, (m0 + 1) % 6);
      end
      key = 1'b1;
      cyc(16);
      m_mode = (m0 + 1) % 6;
      chk_all("hold_rel", sw);
   endtask

   task automatic test_back_to_back();
      logic [3:0] s;
      for (int i = 0; i < 12; i++) begin
         s = 4'($urandom_range(0, 15));
         sw = s;
         if ($urandom_range(0, 1) == 1) press(12);
         else cyc(20);
         chk_all($sformatf("rnd%0d", i), s);
      end
   endtask

   task automatic test_async_reset();
      while (m_mode != 3) press(12);
      chk_all("pre_rst", sw);
      #3 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (mode !== 3'd0 || led !== 6'b111111 || y !== 1'b0) begin
         n_bad++;
         $display("FAIL async_rst: got mode=%0d led=%b y=%b want 0/111111/0",
                  mode, led, y);
      end
      m_mode = 0;
      cyc(2);
      #2 rst_n = 1'b1;
      cyc(1);
   endtask

   task automatic test_straddle();
      sw  = 4'b0000;
      key = 1'b0;
      cyc(8);
      rst_n = 1'b0;
      cyc(3);
      #2 rst_n = 1'b1;
      m_mode = 0;
      cyc(40);
      chk_all("straddle_hold", sw);
      key = 1'b1;
      cyc(16);
      chk_all("straddle_rel", sw);
      press(12);
      chk_all("straddle_press", sw);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_patterns();
      test_mode_cycle();
      test_glitch();
      test_hold();
      test_back_to_back();
      test_async_reset();
      test_straddle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
